// File: rtl/rr_wormhole_allocator.sv
// rr_wormhole_allocator
// Output-port allocator for a five-port mesh router. Grants one requester
// (L, N, E, W, S) at a time in round-robin order, holds the grant for the
// whole packet (wormhole lock), gates flit transfer on downstream credits and
// frees the port through a stall watchdog when the owner stops sending.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req        [4:0]  head-of-buffer flit valid, bit i = requester i
//   flit_id    [14:0] 3 bits per requester: 001 header, 010 body, 100 tail
//   length     [59:0] 12 bits per requester, packet length (valid with header)
//   credit_in  downstream freed one slot this cycle
//   grant      [4:0]  registered one-hot owner
//   sel        [2:0]  registered owner index, 7 when idle
//   xfer       combinational, a flit moves this cycle
//   timeout    registered one-cycle pulse, packet aborted by the watchdog
//   credits    [2:0]  registered available-credit count
module rr_wormhole_allocator #(
    parameter int unsigned CREDITS   = 4,
    parameter int unsigned STALL_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req,
    input  logic [14:0] flit_id,
    input  logic [59:0] length,
    input  logic        credit_in,
    output logic [4:0]  grant,
    output logic [2:0]  sel,
    output logic        xfer,
    output logic        timeout,
    output logic [2:0]  credits
);

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned FID_W     = 3;
    localparam int unsigned LEN_W     = 12;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned CRED_W    = 3;
    localparam int unsigned CSUM_W    = CRED_W + 1;
    localparam int unsigned STALL_W   = 8;
    localparam int unsigned CAND_W    = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [FID_W-1:0]   FLIT_HEAD  = 3'b001;
    localparam logic [FID_W-1:0]   FLIT_TAIL  = 3'b100;
    localparam logic [SEL_W-1:0]   SEL_IDLE   = 3'd7;
    localparam logic [SEL_W-1:0]   LAST_RST   = 3'd4;
    localparam logic [CRED_W-1:0]  CRED_MAX   = CRED_W'(CREDITS);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

    // State registers
    logic [0:0]         state_q,   state_d;
    logic [4:0]         grant_q,   grant_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic [SEL_W-1:0]   last_q,    last_d;
    logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
    logic [LEN_W-1:0]   fcnt_q,    fcnt_d;
    logic [STALL_W-1:0] stall_q,   stall_d;
    logic               timeout_q, timeout_d;
    logic [CRED_W-1:0]  credits_q, credits_d;

    // Per-requester views of the packed input buses
    logic [FID_W-1:0]     fid_arr [NUM_PORTS];
    logic [LEN_W-1:0]     len_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;

    // Arbitration result
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [CAND_W-1:0] cand;

    // Owner's current request and flit type
    logic             owner_req;
    logic [FID_W-1:0] owner_fid;

    logic              xfer_c;
    logic              last_flit;
    logic [CSUM_W-1:0] cred_sum;

    // Split the packed buses per requester
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            fid_arr[i] = flit_id[FID_W*i +: FID_W];
            len_arr[i] = length[LEN_W*i +: LEN_W];
        end
    end

    // Only header flits may open a new packet
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req[i] && (fid_arr[i] == FLIT_HEAD);
        end
    end

    // Round-robin search starting just after the previous owner, wrapping at 5
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = CAND_W'(last_q) + CAND_W'(k);
            if (cand >= CAND_W'(NUM_PORTS)) begin
                cand = cand - CAND_W'(NUM_PORTS);
            end
            if (!win_found && eligible[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // Owner's request/flit type; zero when sel holds the idle code
    always_comb begin
        owner_req = 1'b0;
        owner_fid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                owner_req = req[i];
                owner_fid = fid_arr[i];
            end
        end
    end

    assign xfer_c    = (state_q == BUSY) && owner_req && (credits_q != '0);
    assign last_flit = (owner_fid == FLIT_TAIL) || ((fcnt_q + LEN_W'(1)) == pkt_len_q);

    // Credit counter: xfer and credit_in in the same cycle cancel out
    always_comb begin
        cred_sum  = {1'b0, credits_q} - CSUM_W'(xfer_c) + CSUM_W'(credit_in);
        credits_d = (cred_sum > CSUM_W'(CREDITS)) ? CRED_MAX : cred_sum[CRED_W-1:0];
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        pkt_len_d = pkt_len_q;
        fcnt_d    = fcnt_q;
        stall_d   = stall_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d   = 5'b00001 << win_idx;
                    sel_d     = win_idx;
                    pkt_len_d = (len_arr[win_idx] == '0) ? LEN_W'(1) : len_arr[win_idx];
                    fcnt_d    = '0;
                    stall_d   = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (xfer_c) begin
                    fcnt_d  = fcnt_q + LEN_W'(1);
                    stall_d = '0;
                    if (last_flit) begin
                        grant_d = '0;
                        sel_d   = SEL_IDLE;
                        last_d  = sel_q;
                        state_d = IDLE;
                    end
                end else if (stall_q == STALL_LAST) begin
                    // Owner stopped sending: free the port and flag the abort
                    grant_d   = '0;
                    sel_d     = SEL_IDLE;
                    last_d    = sel_q;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = SEL_IDLE;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= SEL_IDLE;
            last_q    <= LAST_RST;
            pkt_len_q <= '0;
            fcnt_q    <= '0;
            stall_q   <= '0;
            timeout_q <= 1'b0;
            credits_q <= CRED_MAX;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            pkt_len_q <= pkt_len_d;
            fcnt_q    <= fcnt_d;
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
            credits_q <= credits_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign xfer    = xfer_c;
    assign timeout = timeout_q;
    assign credits = credits_q;

endmodule
